// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack, and held word for decode.
// Redirects from later stages replace the PC and squash held/in-flight words.
`timescale 1ns/1ps
module fetch_unit #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [4:0]        opcode,
    output logic [4:0]        func,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_nx;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_nx;
    logic [31:0]       instr_q;
    logic [31:0]       instr_nx;
    logic [ADDR_W-1:0] ipc_q;
    logic [ADDR_W-1:0] ipc_nx;

    // State, PC and held-instruction registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_nx;
            pc_q    <= pc_nx;
            instr_q <= instr_nx;
            ipc_q   <= ipc_nx;
        end
    end

    // Next state: redirect wins, then ack in FETCH, then ready in HOLD
    always_comb begin
        state_nx = state_q;
        pc_nx    = pc_q;
        instr_nx = instr_q;
        ipc_nx   = ipc_q;
        unique case (state_q)
            IDLE: begin
                state_nx = FETCH;
                if (redirect) pc_nx = redirect_pc;
            end
            FETCH: begin
                if (redirect) begin
                    pc_nx = redirect_pc;
                end else if (imem_ack) begin
                    instr_nx = imem_rdata;
                    ipc_nx   = pc_q;
                    pc_nx    = pc_q + ADDR_W'(1);
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nx    = redirect_pc;
                    state_nx = FETCH;
                end else if (out_ready) begin
                    state_nx = FETCH;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign imem_req  = (state_q == FETCH);
    assign out_valid = (state_q == HOLD);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign instr_pc  = ipc_q;
    assign opcode    = instr_q[31:27];
    assign func      = instr_q[6:2];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised + directed bench for fetch_unit against a behavioural model.
// Inputs change on the falling edge; outputs are compared on the falling edge.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int AW = 12;

    logic          clock;
    logic          reset_n;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   instr;
    logic [AW-1:0] instr_pc;
    logic [4:0]    opcode;
    logic [4:0]    func;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [AW-1:0] pc;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 0;

    fetch_unit #(.ADDR_W(AW), .RESET_PC('0)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .opcode     (opcode),
        .func       (func),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .pc         (pc)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    // Behavioural model: has the fetcher left its post-reset cycle,
    // does it currently hold a word, and what PC / word it holds.
    bit          m_started;
    bit          m_holding;
    int unsigned m_pc;
    int unsigned m_instr;
    int unsigned m_ipc;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_started <= 0;
            m_holding <= 0;
            m_pc      <= 0;
            m_instr   <= 0;
            m_ipc     <= 0;
        end else if (!m_started) begin
            m_started <= 1;
            if (redirect) m_pc <= redirect_pc;
        end else if (redirect) begin
            m_pc      <= redirect_pc;
            m_holding <= 0;
        end else if (!m_holding) begin
            if (imem_ack) begin
                m_instr   <= imem_rdata;
                m_ipc     <= m_pc;
                m_pc      <= (m_pc + 1) % 4096;
                m_holding <= 1;
            end
        end else if (out_ready) begin
            m_holding <= 0;
        end
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h",
                     nm, $time, act, exp);
        end
    endtask

    // Compare every cycle against the model
    always @(negedge clock) begin
        if (chk_en) begin
            chk("m_req", 32'(imem_req),
                32'(m_started && !m_holding));
            chk("m_valid", 32'(out_valid), 32'(m_holding));
            chk("m_addr", 32'(imem_addr), m_pc);
            chk("m_pc", 32'(pc), m_pc);
            chk("m_instr", instr, m_instr);
            chk("m_ipc", 32'(instr_pc), m_ipc);
            chk("m_opcode", 32'(opcode), m_instr >> 27);
            chk("m_func", 32'(func), (m_instr >> 2) % 32);
        end
    end

    task automatic idle_in();
        imem_ack    = 0;
        out_ready   = 0;
        redirect    = 0;
        redirect_pc = '0;
        imem_rdata  = '0;
    endtask

    task automatic nxt();
        @(negedge clock);
    endtask

    logic [31:0] kept;

    initial begin
        idle_in();
        reset_n = 0;
        nxt();
        nxt();
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_instr", instr, 0);
        chk_en  = 1;
        reset_n = 1;

        // Sequential zero-wait fetch, word == address, ready high
        for (int c = 0; c < 8; c++) begin
            chk("seq_req", 32'(imem_req), 32'(c % 2));
            if (c % 2 == 1)
                chk("seq_addr", 32'(imem_addr), (c - 1) / 2);
            if (c >= 2 && c % 2 == 0) begin
                chk("seq_valid", 32'(out_valid), 1);
                chk("seq_instr", instr, c / 2 - 1);
                chk("seq_ipc", 32'(instr_pc), c / 2 - 1);
            end
            imem_ack   = imem_req;
            imem_rdata = 32'(imem_addr);
            out_ready  = 1;
            nxt();
        end
        idle_in();

        // Backpressure on a held word
        redirect    = 1;
        redirect_pc = 12'h040;
        nxt();
        idle_in();
        chk("bp_addr", 32'(imem_addr), 32'h40);
        imem_ack   = 1;
        imem_rdata = 32'h2842_0005;
        nxt();
        idle_in();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_opcode", 32'(opcode), 5);
            chk("bp_func", 32'(func), 1);
            chk("bp_req", 32'(imem_req), 0);
            nxt();
        end
        out_ready = 1;
        nxt();
        idle_in();
        chk("bp_next_req", 32'(imem_req), 1);
        chk("bp_next_addr", 32'(imem_addr), 32'h41);

        // Memory wait states
        for (int i = 0; i < 3; i++) begin
            chk("ws_req", 32'(imem_req), 1);
            chk("ws_addr", 32'(imem_addr), 32'h41);
            nxt();
        end
        kept       = 32'hA5A5_0F0F;
        imem_ack   = 1;
        imem_rdata = kept;
        nxt();
        idle_in();
        chk("ws_ipc", 32'(instr_pc), 32'h41);
        chk("ws_pc", 32'(pc), 32'h42);

        // Redirect in HOLD with ready high
        out_ready   = 1;
        redirect    = 1;
        redirect_pc = 12'h100;
        nxt();
        idle_in();
        chk("rh_valid", 32'(out_valid), 0);
        chk("rh_addr", 32'(imem_addr), 32'h100);

        // Redirect colliding with ack
        imem_ack    = 1;
        imem_rdata  = 32'hDEAD_BEEF;
        redirect    = 1;
        redirect_pc = 12'h100;
        nxt();
        idle_in();
        chk("rc_instr", instr, kept);
        chk("rc_addr", 32'(imem_addr), 32'h100);
        chk("rc_valid", 32'(out_valid), 0);
        chk("rc_req", 32'(imem_req), 1);

        // PC wrap
        redirect    = 1;
        redirect_pc = 12'hFFF;
        nxt();
        idle_in();
        imem_ack   = 1;
        imem_rdata = 32'h1234_5678;
        nxt();
        idle_in();
        chk("wr_ipc", 32'(instr_pc), 32'hFFF);
        chk("wr_pc", 32'(pc), 0);
        out_ready = 1;
        nxt();
        idle_in();
        chk("wr_addr", 32'(imem_addr), 0);
        chk("wr_req", 32'(imem_req), 1);

        // Async reset between edges while fetching
        @(posedge clock);
        #2 reset_n = 0;
        #1;
        chk("ar_req", 32'(imem_req), 0);
        chk("ar_valid", 32'(out_valid), 0);
        chk("ar_pc", 32'(pc), 0);
        chk("ar_instr", instr, 0);
        chk("ar_ipc", 32'(instr_pc), 0);
        nxt();
        nxt();
        reset_n = 1;
        chk("ar_idle", 32'(imem_req), 0);
        nxt();
        chk("ar_req1", 32'(imem_req), 1);
        chk("ar_addr", 32'(imem_addr), 0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            imem_ack   = ($urandom_range(2) == 0);
            imem_rdata = $urandom;
            out_ready  = ($urandom_range(1) == 1);
            redirect   = ($urandom_range(11) == 0);
            if ($urandom_range(3) == 0)
                redirect_pc = 12'hFFF;
            else
                redirect_pc = 12'($urandom);
            nxt();
        end
        idle_in();
        nxt();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the control decoder. It holds the program counter and requests instruction words from instruction memory over a req/ack handshake. It latches each returned word and presents it, with its PC, to the decode/control stage over a valid/ready handshake. The decoder's `opcode` and `Func` fields are sliced here, so decode consumes them without further wiring. Branch/jump redirects from later stages replace the PC and squash any in-flight or held instruction.

## Interface
Parameters:
- `ADDR_W`, 12, instruction memory word-address width; PC width.
- `RESET_PC`, 0, PC value loaded on reset.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  instruction read request.
- `imem_addr`  out  ADDR_W  word address of the request; equals `pc`.
- `imem_ack`  in  1  one-cycle pulse: `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `out_valid`  out  1  held instruction valid to decode.
- `out_ready`  in  1  decode accepts the held instruction.
- `instr`  out  32  held instruction word.
- `instr_pc`  out  ADDR_W  address the held instruction was fetched from.
- `opcode`  out  5  `instr[31:27]`.
- `func`  out  5  `instr[6:2]` (ALU op field).
- `redirect`  in  1  load a new PC and squash.
- `redirect_pc`  in  ADDR_W  target PC.
- `pc`  out  ADDR_W  current fetch PC.

## Operation
- Reset (async assert, `reset_n`=0):
  - `pc`=RESET_PC; state=IDLE.
  - `instr`=0, `instr_pc`=0.
  - `out_valid`=0, `imem_req`=0.
  - `opcode`/`func`=0.
- States:
  - IDLE: only after reset. Unconditionally goes to FETCH on the next edge. `imem_req`=0.
  - FETCH: `imem_req`=1, `imem_addr`=`pc`. On `imem_ack`:
    - `instr`<=`imem_rdata`, `instr_pc`<=`pc`.
    - `pc`<=`pc`+1, truncated to ADDR_W bits (all-ones wraps to 0).
    - Go to HOLD.
  - HOLD: `out_valid`=1, `imem_req`=0. On `out_ready`=1, go to FETCH; `instr`/`instr_pc` keep their values until overwritten.
- `imem_ack` outside FETCH is ignored.
- `out_ready` outside HOLD is ignored.
- Redirect has highest priority and applies in any non-IDLE state:
  - `pc`<=`redirect_pc`; next state FETCH.
  - `out_valid` drops to 0 on the next cycle. The held instruction is discarded even if `out_ready` was high in the same cycle; decode must not treat that cycle's handshake as consumed.
  - An `imem_ack` in the same cycle is discarded: `instr` and `instr_pc` are unchanged.
- Redirect in IDLE: `pc`<=`redirect_pc` and go to FETCH.
- `imem_req` must not drop in FETCH until ack or redirect. Memory may take any number of cycles.
- `opcode` and `func` are combinational slices of the `instr` register.

## Timing
- Reset release to first `imem_req`=1: 1 cycle (IDLE lasts exactly one cycle).
- Ack in cycle N: `out_valid`=1 and new `instr` visible in cycle N+1.
- Handshake in cycle M (`out_valid`&`out_ready`): `imem_req`=1 with the next `pc` in cycle M+1.
- Peak throughput with zero-wait memory and `out_ready` tied high: one instruction per 2 cycles.
- Redirect in cycle R: `imem_addr`=`redirect_pc` and `out_valid`=0 in cycle R+1.
- All outputs are registered or decoded from state registers. No combinational path from `out_ready`, `imem_ack` or `redirect` to any output.

## Test plan
- Reset/sequential fetch, RESET_PC=0, zero-wait memory returning word=address, `out_ready`=1:
  - `imem_addr` is 0,1,2,3 in cycles 1,3,5,7.
  - `instr`/`instr_pc` are 0/0, 1/1, 2/2.
  - `out_valid` alternates 0,1.
- Backpressure: `out_ready`=0 for 5 cycles while HOLD with `instr`=0x2842_0005:
  - `out_valid` stays 1.
  - `opcode`=5 and `func`=1 are stable.
  - `imem_req`=0 throughout.
  - On `out_ready`=1, the next request appears the following cycle.
- Wait states: ack delayed 3 cycles → `imem_req` and `imem_addr` stay constant until ack; PC advances by exactly 1.
- Redirect collisions:
  - Redirect to 0x100 in the same cycle as `imem_ack` (rdata 0xDEADBEEF) → `instr` unchanged, next `imem_addr`=0x100, `out_valid`=0.
  - Redirect during HOLD with `out_ready`=1 → held instruction dropped, fetch from 0x100.
- Wrap: `pc`=0xFFF fetch → `instr_pc`=0xFFF, next `imem_addr`=0x000.
- Async reset mid-FETCH (`reset_n` low between edges):
  - Outputs clear immediately, without a clock edge.
  - After release, IDLE lasts 1 cycle, then `imem_addr`=RESET_PC.
